// File: rtl/bip_datapath_ext.sv
// Accumulator datapath for a small BIP-style CPU: single-cycle ALU ops plus a
// multi-cycle shift-add unsigned multiply, with registered {Z,N,C,V} flags.
module bip_datapath_ext #(
    parameter int NB_BITS = 16,
    parameter int NB_SIGX = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_data_mem,
    input  logic [NB_SIGX-1:0] i_data_ins,
    input  logic [1:0]         i_sel_a,
    input  logic               i_sel_b,
    input  logic [2:0]         i_op,
    input  logic               i_wr_acc,
    output logic [NB_BITS-1:0] o_acc,
    output logic [NB_BITS-1:0] o_data,
    output logic [3:0]         o_flags,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_dbg_state
);

    localparam int CNT_W = $clog2(NB_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NB_BITS - 1);

    localparam logic [2:0] OP_SUB  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
    localparam logic [2:0] OP_SRA1 = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [1:0] SRC_MEM  = 2'b00;
    localparam logic [1:0] SRC_IMM  = 2'b01;
    localparam logic [1:0] SRC_ALU  = 2'b10;
    localparam logic [1:0] SRC_HOLD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state;
    logic [NB_BITS-1:0] acc;
    logic [3:0]         flags;
    logic               busy;
    logic               done;

    logic [NB_BITS-1:0] mcand;
    logic [NB_BITS-1:0] mplier;
    logic [NB_BITS-1:0] prod;
    logic [CNT_W-1:0]   cnt;

    logic [NB_BITS-1:0] imm;
    logic [NB_BITS-1:0] opnd_b;
    logic [NB_BITS-1:0] b_eff;
    logic [NB_BITS:0]   sum;
    logic               alu_v;
    logic [NB_BITS-1:0] alu_res;
    logic [NB_BITS-1:0] acc_next;
    logic               wr_cv;
    logic               mul_req;
    logic [NB_BITS-1:0] prod_next;

    // SUB is folded into the adder as A + ~B + 1 so C means "no borrow".
    always_comb begin
        imm    = NB_BITS'($signed(i_data_ins));
        opnd_b = i_sel_b ? imm : i_data_mem;
        b_eff  = (i_op == OP_SUB) ? ~opnd_b : opnd_b;
        sum    = {1'b0, acc} + {1'b0, b_eff} + {{NB_BITS{1'b0}}, (i_op == OP_SUB)};
        alu_v  = (acc[NB_BITS-1] == b_eff[NB_BITS-1]) && (sum[NB_BITS-1] != acc[NB_BITS-1]);

        alu_res = '0;
        case (i_op)
            OP_SUB, OP_ADD: alu_res = sum[NB_BITS-1:0];
            OP_AND:         alu_res = acc & opnd_b;
            OP_OR:          alu_res = acc | opnd_b;
            OP_XOR:         alu_res = acc ^ opnd_b;
            OP_SHL1:        alu_res = acc << 1;
            OP_SRA1:        alu_res = $unsigned($signed(acc) >>> 1);
            default:        alu_res = '0;
        endcase

        acc_next = acc;
        case (i_sel_a)
            SRC_MEM:  acc_next = i_data_mem;
            SRC_IMM:  acc_next = imm;
            SRC_ALU:  acc_next = alu_res;
            SRC_HOLD: acc_next = acc;
            default:  acc_next = acc;
        endcase

        wr_cv     = (i_sel_a == SRC_ALU) && ((i_op == OP_ADD) || (i_op == OP_SUB));
        mul_req   = (i_sel_a == SRC_ALU) && (i_op == OP_MUL);
        prod_next = prod + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            acc    <= '0;
            flags  <= 4'b0000;
            busy   <= 1'b0;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_wr_acc) begin
                        if (mul_req) begin
                            state  <= ST_MUL;
                            busy   <= 1'b1;
                            mcand  <= acc;
                            mplier <= opnd_b;
                            prod   <= '0;
                            cnt    <= '0;
                        end else begin
                            acc   <= acc_next;
                            flags <= {(acc_next == '0), acc_next[NB_BITS-1],
                                      wr_cv & sum[NB_BITS], wr_cv & alu_v};
                        end
                    end
                end
                ST_MUL: begin
                    // One shift-add step per cycle; all control inputs ignored here.
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        acc   <= prod_next;
                        flags <= {(prod_next == '0), prod_next[NB_BITS-1], 2'b00};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_acc       = acc;
    assign o_data      = acc;
    assign o_flags     = flags;
    assign o_busy      = busy;
    assign o_done      = done;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_bip_datapath_ext.sv
// Directed bench for bip_datapath_ext: reference model feeds an expected queue,
// results are popped and compared when the accumulator write lands.
module tb_bip_datapath_ext;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_data_mem;
    logic [10:0] i_data_ins;
    logic [1:0]  i_sel_a;
    logic        i_sel_b;
    logic [2:0]  i_op;
    logic        i_wr_acc;
    logic [15:0] o_acc;
    logic [15:0] o_data;
    logic [3:0]  o_flags;
    logic        o_busy;
    logic        o_done;
    logic        o_dbg_state;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_q[$];
    logic [15:0] ref_acc;
    logic [3:0]  ref_flags;

    bip_datapath_ext #(.NB_BITS(16), .NB_SIGX(11)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data_mem  (i_data_mem),
        .i_data_ins  (i_data_ins),
        .i_sel_a     (i_sel_a),
        .i_sel_b     (i_sel_b),
        .i_op        (i_op),
        .i_wr_acc    (i_wr_acc),
        .o_acc       (o_acc),
        .o_data      (o_data),
        .o_flags     (o_flags),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_dbg_state (o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sext(input logic [10:0] ins);
        return {{5{ins[10]}}, ins};
    endfunction

    // Reference: {acc[15:0], Z, N, C, V} after a write with the given controls.
    function automatic logic [19:0] model(input logic [1:0] sa, input logic sb,
                                          input logic [2:0] op, input logic [15:0] mem,
                                          input logic [10:0] ins, input logic [15:0] a);
        logic [15:0] b, r;
        logic        c, v;
        int          s;
        b = sb ? sext(ins) : mem;
        c = 1'b0;
        v = 1'b0;
        r = a;
        case (sa)
            2'b00: r = mem;
            2'b01: r = sext(ins);
            2'b11: r = a;
            default: begin
                case (op)
                    3'b001: begin
                        r = a + b;
                        c = (32'(a) + 32'(b)) > 32'hFFFF;
                        s = int'($signed(a)) + int'($signed(b));
                        v = (s > 32767) || (s < -32768);
                    end
                    3'b000: begin
                        r = a - b;
                        c = (a >= b);
                        s = int'($signed(a)) - int'($signed(b));
                        v = (s > 32767) || (s < -32768);
                    end
                    3'b010: r = a & b;
                    3'b011: r = a | b;
                    3'b100: r = a ^ b;
                    3'b101: r = {a[14:0], 1'b0};
                    3'b110: r = {a[15], a[15:1]};
                    default: r = 16'h0000;
                endcase
            end
        endcase
        return {r, (r == 16'h0000), r[15], c, v};
    endfunction

    task automatic op_step(input string tag, input logic [1:0] sa, input logic sb,
                           input logic [2:0] op, input logic [15:0] mem,
                           input logic [10:0] ins, input logic wr);
        logic [19:0] e;
        i_sel_a    = sa;
        i_sel_b    = sb;
        i_op       = op;
        i_data_mem = mem;
        i_data_ins = ins;
        i_wr_acc   = wr;
        if (wr) exp_q.push_back(model(sa, sb, op, mem, ins, ref_acc));
        @(posedge i_clk);
        #1;
        i_wr_acc = 1'b0;
        if (wr) begin
            e = exp_q.pop_front();
            ref_acc   = e[19:4];
            ref_flags = e[3:0];
        end
        check({tag, " acc"}, 32'(o_acc), 32'(ref_acc));
        check({tag, " flags"}, 32'(o_flags), 32'(ref_flags));
        check({tag, " data"}, 32'(o_data), 32'(ref_acc));
    endtask

    // Issues a multiply and follows it to o_done; returns in the done cycle.
    task automatic mul_run(input string tag, input logic sb, input logic [15:0] mem,
                           input logic [10:0] ins);
        logic [31:0] p;
        logic [15:0] r;
        logic [19:0] e;
        int          n;
        p = 32'(ref_acc) * 32'(sb ? sext(ins) : mem);
        r = p[15:0];
        exp_q.push_back({r, (r == 16'h0000), r[15], 2'b00});
        i_sel_a    = 2'b10;
        i_sel_b    = sb;
        i_op       = 3'b111;
        i_data_mem = mem;
        i_data_ins = ins;
        i_wr_acc   = 1'b1;
        @(posedge i_clk);
        #1;
        i_wr_acc = 1'b0;
        n = 0;
        while (o_busy === 1'b1 && n < 40) begin
            check({tag, " done low while busy"}, 32'(o_done), 32'd0);
            check({tag, " acc held"}, 32'(o_acc), 32'(ref_acc));
            check({tag, " flags held"}, 32'(o_flags), 32'(ref_flags));
            // Junk writes that must be ignored while multiplying.
            i_wr_acc   = 1'($urandom_range(0, 1));
            i_sel_a    = 2'($urandom_range(0, 3));
            i_op       = 3'($urandom_range(0, 7));
            i_data_mem = 16'($urandom_range(0, 65535));
            @(posedge i_clk);
            #1;
            n++;
        end
        i_wr_acc = 1'b0;
        check({tag, " busy cycles"}, 32'(n), 32'd16);
        check({tag, " done pulse"}, 32'(o_done), 32'd1);
        check({tag, " busy clear"}, 32'(o_busy), 32'd0);
        e = exp_q.pop_front();
        ref_acc   = e[19:4];
        ref_flags = e[3:0];
        check({tag, " result"}, 32'(o_acc), 32'(ref_acc));
        check({tag, " flags"}, 32'(o_flags), 32'(ref_flags));
    endtask

    initial begin
        int done_seen;
        i_rst      = 1'b1;
        i_data_mem = 16'h0000;
        i_data_ins = 11'h000;
        i_sel_a    = 2'b11;
        i_sel_b    = 1'b0;
        i_op       = 3'b001;
        i_wr_acc   = 1'b0;
        ref_acc    = 16'h0000;
        ref_flags  = 4'b0000;

        // Reset held for two cycles.
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("reset acc", 32'(o_acc), 32'h0000);
        check("reset flags", 32'(o_flags), 32'h0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset done", 32'(o_done), 32'd0);
        check("reset state", 32'(o_dbg_state), 32'd0);

        op_step("load imm", 2'b01, 1'b0, 3'b001, 16'h0000, 11'h7FF, 1'b1);
        check("load imm const", {16'h0, o_acc}, 32'hFFFF);
        check("load imm flags const", 32'(o_flags), 32'b0100);

        op_step("load mem", 2'b00, 1'b0, 3'b001, 16'h7FFF, 11'h000, 1'b1);
        op_step("add ovf", 2'b10, 1'b0, 3'b001, 16'h0001, 11'h000, 1'b1);
        check("add ovf const", 32'(o_acc), 32'h8000);
        check("add ovf flags const", 32'(o_flags), 32'b0101);

        op_step("load 5", 2'b00, 1'b0, 3'b001, 16'h0005, 11'h000, 1'b1);
        op_step("sub zero", 2'b10, 1'b0, 3'b000, 16'h0005, 11'h000, 1'b1);
        check("sub zero const", 32'(o_acc), 32'h0000);
        check("sub zero flags const", 32'(o_flags), 32'b1010);

        op_step("no write", 2'b00, 1'b0, 3'b001, 16'h1234, 11'h000, 1'b0);
        op_step("hold write", 2'b11, 1'b0, 3'b001, 16'h1234, 11'h000, 1'b1);
        check("hold clears cv", 32'(o_flags), 32'b1000);

        for (int i = 0; i < 24; i++) begin
            op_step("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 6)), 16'($urandom_range(0, 65535)),
                    11'($urandom_range(0, 2047)), 1'b1);
        end

        op_step("load 12", 2'b00, 1'b0, 3'b001, 16'h0012, 11'h000, 1'b1);
        mul_run("mul imm", 1'b1, 16'h0000, 11'h007);
        check("mul const", 32'(o_acc), 32'h007E);
        // Back-to-back request issued in the done cycle.
        mul_run("mul b2b", 1'b0, 16'h0003, 11'h000);
        op_step("after mul", 2'b00, 1'b0, 3'b001, 16'h0000, 11'h000, 1'b0);
        check("done one cycle", 32'(o_done), 32'd0);

        op_step("load 100", 2'b00, 1'b0, 3'b001, 16'h0100, 11'h000, 1'b1);
        mul_run("mul trunc", 1'b0, 16'h0300, 11'h000);
        check("mul trunc const", 32'(o_acc), 32'h0000);

        // Reset on the fifth busy cycle aborts the multiply.
        op_step("load 33", 2'b00, 1'b0, 3'b001, 16'h0033, 11'h000, 1'b1);
        i_sel_a  = 2'b10;
        i_op     = 3'b111;
        i_sel_b  = 1'b1;
        i_data_ins = 11'h005;
        i_wr_acc = 1'b1;
        @(posedge i_clk);
        #1;
        i_wr_acc = 1'b0;
        check("rst mul busy", 32'(o_busy), 32'd1);
        check("rst mul state", 32'(o_dbg_state), 32'd1);
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        ref_acc   = 16'h0000;
        ref_flags = 4'b0000;
        check("rst mul acc", 32'(o_acc), 32'h0000);
        check("rst mul busy clear", 32'(o_busy), 32'd0);
        check("rst mul flags", 32'(o_flags), 32'h0);
        done_seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (o_done === 1'b1) done_seen++;
            @(posedge i_clk);
            #1;
        end
        check("rst mul no done", 32'(done_seen), 32'd0);
        check("rst mul acc stays", 32'(o_acc), 32'h0000);
        check("queue drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
